// File: rtl/spi_flash_pkg.sv
// Shared SPI NOR flash definitions: opcodes, read-FSM states and header layout.
// Imported by the read, erase and status-poll blocks.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_CE   = 8'hC7;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  localparam int unsigned HDR_W = 32;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_CS_SETUP,
    RD_CMD,
    RD_ADDR,
    RD_DATA,
    RD_CS_HOLD,
    RD_CS_IDLE
  } rd_state_e;

  // Opcode followed by 24-bit address, shifted out MSB first.
  typedef struct packed {
    logic [7:0]  cmd;
    logic [23:0] addr;
  } spi_hdr_t;

  function automatic spi_hdr_t make_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    spi_hdr_t h;
    h.cmd  = cmd;
    h.addr = addr;
    return h;
  endfunction

endpackage

// File: rtl/spi_bit_clk.sv
// SPI mode-0 bit timing: phase counter, registered SCK and per-phase strobes.
// Counter holds at phase 0 while disabled so the first enabled cycle is a bit start.
module spi_bit_clk #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic spi_clk,
  output logic shift_c,
  output logic sample_c,
  output logic last_c
);

  localparam int unsigned PH_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALF = CLK_DIV / 2;

  logic [PH_W-1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (!en || (phase == PH_W'(CLK_DIV - 1))) begin
      phase <= '0;
    end else begin
      phase <= phase + PH_W'(1);
    end
  end

  // SCK high for the second half of each bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_clk <= 1'b0;
    end else begin
      spi_clk <= en && (phase >= PH_W'(HALF));
    end
  end

  assign shift_c  = en && (phase == '0);
  assign sample_c = en && (phase == PH_W'(HALF));
  assign last_c   = en && (phase == PH_W'(CLK_DIV - 1));

endmodule

// File: rtl/spi_flash_read.sv
// Flash READ (0x03) engine: sends opcode + address, clocks in len bytes and
// streams them out one per rd_valid pulse. SPI mode 0, MSB first.
module spi_flash_read
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned CS_SETUP_CYC = 4,
  parameter int unsigned CS_HOLD_CYC  = 4,
  parameter int unsigned CS_IDLE_CYC  = 5,
  parameter int unsigned LEN_W        = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             spi_clk,
  output logic             cs,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int unsigned CYC_MAX_SH = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int unsigned CYC_MAX    = (CYC_MAX_SH > CS_IDLE_CYC) ? CYC_MAX_SH : CS_IDLE_CYC;
  localparam int unsigned CNT_W      = $clog2(CYC_MAX + 1);
  localparam int unsigned BIT_W      = 5;

  rd_state_e        state, state_nxt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic [HDR_W-1:0] tx_sr;
  logic [7:0]       rx_sr;
  logic             byte_rdy;

  logic spi_en;
  logic shift_c, sample_c, last_c;
  logic start_ok_c, byte_end_c;
  logic cs_c, busy_c, done_c, mosi_c;

  assign spi_en     = state inside {RD_CMD, RD_ADDR, RD_DATA};
  assign start_ok_c = (state == RD_IDLE) && start;
  assign byte_end_c = last_c && (state == RD_DATA) && (bit_cnt[2:0] == 3'd7);

  spi_bit_clk #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_clk (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (spi_en),
    .spi_clk  (spi_clk),
    .shift_c  (shift_c),
    .sample_c (sample_c),
    .last_c   (last_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? RD_CS_IDLE : RD_CS_SETUP;
        end
      end
      RD_CS_SETUP: begin
        if (cyc_cnt == CNT_W'(CS_SETUP_CYC - 1)) state_nxt = RD_CMD;
      end
      RD_CMD: begin
        if (last_c && (bit_cnt == BIT_W'(7))) state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        if (last_c && (bit_cnt == BIT_W'(31))) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (byte_end_c && (byte_cnt == LEN_W'(1))) state_nxt = RD_CS_HOLD;
      end
      RD_CS_HOLD: begin
        if (cyc_cnt == CNT_W'(CS_HOLD_CYC - 1)) state_nxt = RD_CS_IDLE;
      end
      RD_CS_IDLE: begin
        if (cyc_cnt == CNT_W'(CS_IDLE_CYC)) state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // CS_IDLE runs one extra cycle so cs is high CS_IDLE_CYC clocks before done;
  // a zero-length request enters it one cycle from the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (state_nxt != state) begin
      cyc_cnt <= ((state == RD_IDLE) && (state_nxt == RD_CS_IDLE)) ? CNT_W'(CS_IDLE_CYC - 1) : '0;
    end else if (state inside {RD_CS_SETUP, RD_CS_HOLD, RD_CS_IDLE}) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end

  // Shift registers and bit/byte counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      byte_rdy <= 1'b0;
    end else begin
      if (start_ok_c) begin
        tx_sr    <= make_hdr(CMD_READ, addr);
        byte_cnt <= len;
        bit_cnt  <= '0;
      end else begin
        if (shift_c && (state inside {RD_CMD, RD_ADDR})) begin
          tx_sr <= {tx_sr[HDR_W-2:0], 1'b0};
        end
        if (last_c) begin
          bit_cnt <= ((state == RD_ADDR) && (bit_cnt == BIT_W'(31))) ? '0 : bit_cnt + BIT_W'(1);
        end
        if (byte_end_c) begin
          byte_cnt <= byte_cnt - LEN_W'(1);
        end
      end
      if (sample_c && (state == RD_DATA)) begin
        rx_sr <= {rx_sr[6:0], spi_miso};
      end
      byte_rdy <= sample_c && (state == RD_DATA) && (bit_cnt[2:0] == 3'd7);
    end
  end

  always_comb begin
    cs_c   = 1'b1;
    done_c = 1'b0;
    busy_c = 1'b0;
    mosi_c = spi_mosi;
    if (state inside {RD_CS_SETUP, RD_CMD, RD_ADDR, RD_DATA, RD_CS_HOLD}) begin
      cs_c = 1'b0;
    end
    if ((state == RD_CS_IDLE) && (cyc_cnt == CNT_W'(CS_IDLE_CYC))) begin
      done_c = 1'b1;
    end
    busy_c = (state != RD_IDLE) && !done_c;
    if (!spi_en) begin
      mosi_c = 1'b0;
    end else if (shift_c) begin
      mosi_c = (state inside {RD_CMD, RD_ADDR}) && tx_sr[HDR_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_mosi <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      cs       <= cs_c;
      busy     <= busy_c;
      done     <= done_c;
      spi_mosi <= mosi_c;
      rd_valid <= byte_rdy;
      if (byte_rdy) begin
        rd_data <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_read.sv
// Bench for spi_flash_read: mode-0 flash model with sparse memory and
// transaction-level expectations for timing, data and bus framing.
module tb_spi_flash_read;

  localparam int unsigned CLK_DIV      = 4;
  localparam int unsigned CS_SETUP_CYC = 4;
  localparam int unsigned CS_HOLD_CYC  = 4;
  localparam int unsigned CS_IDLE_CYC  = 5;
  localparam int unsigned LEN_W        = 9;
  localparam int unsigned FIRST_RV     = 1 + CS_SETUP_CYC + 40 * CLK_DIV - CLK_DIV / 2 + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [23:0]      addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, rd_valid, spi_clk, cs, spi_mosi;
  logic [7:0]       rd_data;
  logic             spi_miso = 1'b0;

  spi_flash_read #(
    .CLK_DIV      (CLK_DIV),
    .CS_SETUP_CYC (CS_SETUP_CYC),
    .CS_HOLD_CYC  (CS_HOLD_CYC),
    .CS_IDLE_CYC  (CS_IDLE_CYC),
    .LEN_W        (LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .addr     (addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .spi_clk  (spi_clk),
    .cs       (cs),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc++;

  logic [7:0] mem [logic [23:0]];

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : 8'hFF;
  endfunction

  // Flash model: capture opcode/address on SCK rise, present data on SCK fall.
  int unsigned m_bits = 0;
  int unsigned m_last_bits = 0;
  int unsigned m_idx;
  logic [7:0]  m_op = '0;
  logic [23:0] m_addr = '0;
  logic [7:0]  m_byte;
  int          cs_falls = 0;

  always @(posedge spi_clk or posedge cs) begin
    if (cs === 1'b1) begin
      m_last_bits = m_bits;
      m_bits = 0;
    end else begin
      if (m_bits < 8) m_op = {m_op[6:0], spi_mosi};
      else if (m_bits < 32) m_addr = {m_addr[22:0], spi_mosi};
      m_bits++;
    end
  end

  always @(negedge spi_clk) begin
    if (cs === 1'b0 && m_bits >= 32) begin
      m_idx    = m_bits - 32;
      m_byte   = mem_rd(m_addr + 24'(m_idx / 8));
      spi_miso = m_byte[3'(7 - (m_idx % 8))];
    end
  end

  always @(negedge cs) cs_falls++;

  int unsigned rv_cyc[$];
  logic [7:0]  rv_dat[$];
  int unsigned dn_cyc[$];

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      rv_cyc.push_back(cyc);
      rv_dat.push_back(rd_data);
    end
    if (done === 1'b1) dn_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [23:0] a, input int unsigned n);
    for (int i = 0; i < int'(n); i++) mem[a + 24'(i)] = 8'($urandom);
  endtask

  // One full transaction; poke re-pulses start while busy.
  task automatic run_txn(input logic [23:0] a, input int unsigned n, input bit poke);
    int unsigned t, total, lim;
    int rv_base, dn_base, f_base, got;
    rv_base = rv_cyc.size();
    dn_base = dn_cyc.size();
    f_base  = cs_falls;
    total = (n == 0) ? 2 : 1 + CS_SETUP_CYC + (32 + 8 * n) * CLK_DIV + CS_HOLD_CYC + CS_IDLE_CYC;
    @(negedge clk);
    addr = a; len = LEN_W'(n); start = 1'b1; t = cyc + 1;
    @(negedge clk);
    start = 1'b0; addr = 24'($urandom); len = LEN_W'($urandom);
    @(negedge clk);
    chk("busy_rise", 32'(busy), 32'(1));
    chk("cs_at_t1", 32'(cs), 32'(n == 0));
    if (poke) begin
      repeat (8) @(negedge clk);
      start = 1'b1; len = LEN_W'(3);
      @(negedge clk);
      start = 1'b0;
    end
    lim = t + total + 50;
    while (dn_cyc.size() == dn_base && cyc < lim) @(negedge clk);
    repeat (40) @(negedge clk);
    got = dn_cyc.size() - dn_base;
    chk("done_count", 32'(got), 32'(1));
    if (got > 0) chk("done_time", 32'(dn_cyc[dn_base] - t), 32'(total));
    got = rv_cyc.size() - rv_base;
    chk("rv_count", 32'(got), 32'(n));
    for (int i = 0; i < int'(n) && i < got; i++) begin
      chk("rd_data", 32'(rv_dat[rv_base + i]), 32'(mem_rd(a + 24'(i))));
      chk("rv_time", 32'(rv_cyc[rv_base + i] - t), 32'(FIRST_RV + i * 8 * CLK_DIV));
    end
    chk("cs_falls", 32'(cs_falls - f_base), 32'((n == 0) ? 0 : 1));
    if (n != 0) begin
      chk("opcode", 32'(m_op), 32'(8'h03));
      chk("address", 32'(m_addr), 32'(a));
      chk("sck_count", 32'(m_last_bits), 32'(32 + 8 * n));
    end
    chk("busy_end", 32'(busy), 32'(0));
    chk("cs_end", 32'(cs), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_cs, bad_clk, bad_busy, rv_base, dn_base;
    int unsigned lim;
    logic [23:0] ra;
    int unsigned rn;

    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'(1));
    chk("rst_sck", 32'(spi_clk), 32'(0));
    chk("rst_mosi", 32'(spi_mosi), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rv", 32'(rd_valid), 32'(0));
    chk("rst_data", 32'(rd_data), 32'(0));
    rst_n = 1'b1;

    bad_cs = 0; bad_clk = 0; bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cs !== 1'b1) bad_cs++;
      if (spi_clk !== 1'b0) bad_clk++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("idle_cs_bad_cycles", 32'(bad_cs), 32'(0));
    chk("idle_sck_bad_cycles", 32'(bad_clk), 32'(0));
    chk("idle_busy_bad_cycles", 32'(bad_busy), 32'(0));

    run_txn(24'h000000, 4, 1'b0);

    mem[24'h123456] = 8'hA5;
    mem[24'h123457] = 8'h3C;
    run_txn(24'h123456, 2, 1'b0);

    run_txn(24'($urandom), 0, 1'b0);

    ra = 24'($urandom);
    fill(ra, 2);
    run_txn(ra, 2, 1'b1);

    for (int k = 0; k < 4; k++) begin
      ra = 24'($urandom);
      rn = $urandom_range(1, 6);
      fill(ra, rn);
      run_txn(ra, rn, 1'b0);
    end

    // Abort during the second data byte.
    ra = 24'($urandom);
    fill(ra, 4);
    rv_base = rv_cyc.size();
    dn_base = dn_cyc.size();
    @(negedge clk);
    addr = ra; len = LEN_W'(4); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lim = cyc + 400;
    while (rv_cyc.size() == rv_base && cyc < lim) @(negedge clk);
    chk("abort_first_byte_seen", 32'(rv_cyc.size() - rv_base), 32'(1));
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(cs), 32'(1));
    chk("abort_sck", 32'(spi_clk), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_mosi", 32'(spi_mosi), 32'(0));
    chk("abort_data", 32'(rd_data), 32'(0));
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("abort_no_done", 32'(dn_cyc.size() - dn_base), 32'(0));

    ra = 24'($urandom);
    fill(ra, 3);
    run_txn(ra, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
